// File: rtl/reg_writeback.sv
// Write-back queue merging ALU and load results into one register-file write port.
// Optional WB_FORWARD_EN adds q_fwd_valid/q_fwd_data forwarding of the youngest queued match.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [4:0]                alu_rd,
  input  logic [31:0]               alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [4:0]                ld_rd,
  input  logic [31:0]               ld_data,
  input  logic                      wb_stall,
  output logic                      wb_we,
  output logic [4:0]                wb_addr,
  output logic [31:0]               wb_data,
  input  logic [4:0]                q_addr,
  output logic                      q_busy,
`ifdef WB_FORWARD_EN
  output logic                      q_fwd_valid,
  output logic [31:0]               q_fwd_data,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic          not_full;
  logic          not_empty;
  logic          ld_fire;
  logic          alu_fire;
  logic          enq;
  logic          deq;
  logic [4:0]    enq_rd;
  logic [31:0]   enq_data;
  logic [DEPTH-1:0] slot_hit;

  // Full-ness comes from the registered count only, so a dequeue never frees a slot the same cycle.
  assign not_full  = count_reg < CW'(DEPTH);
  assign not_empty = count_reg != '0;

  assign ld_ready  = !rst || not_full;
  assign alu_ready = !rst || (not_full && !ld_valid);

  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign enq_rd    = ld_fire ? ld_rd : alu_rd;
  assign enq_data  = ld_fire ? ld_data : alu_data;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign enq       = (ld_fire || alu_fire) && (enq_rd != 5'd0);

  assign wb_we     = not_empty && !wb_stall;
  assign deq       = wb_we;
  assign wb_addr   = not_empty ? rd_mem[rd_ptr_reg]   : 5'd0;
  assign wb_data   = not_empty ? data_mem[rd_ptr_reg] : 32'd0;

  assign count_next = count_reg + CW'(enq) - CW'(deq);
  assign count      = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr_reg]   <= enq_rd;
      data_mem[wr_ptr_reg] <= enq_data;
    end
  end

  // A slot is live when its distance from the head is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] age;
      assign age          = AW'(gi) - rd_ptr_reg;
      assign slot_hit[gi] = ({1'b0, age} < count_reg) && (rd_mem[gi] == q_addr);
    end
  endgenerate

  assign q_busy = (q_addr != 5'd0) && (|slot_hit);

`ifdef WB_FORWARD_EN
  assign q_fwd_valid = q_busy;

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    q_fwd_data = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (q_busy && slot_hit[rd_ptr_reg + AW'(k)])
        q_fwd_data = data_mem[rd_ptr_reg + AW'(k)];
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed stimulus pushes expected writes, a monitor pops them.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        wb_stall = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  q_addr = '0;
  logic        q_busy;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_FORWARD_EN
  logic        q_fwd_valid;
  logic [31:0] q_fwd_data;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_stall(wb_stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .q_addr(q_addr), .q_busy(q_busy),
`ifdef WB_FORWARD_EN
    .q_fwd_valid(q_fwd_valid), .q_fwd_data(q_fwd_data),
`endif
    .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && wb_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no write", wb_addr, wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_addr, wb_data} !== e) begin
          miscompares++;
          $display("FAIL wb_write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                   wb_addr, wb_data, e[36:32], e[31:0]);
        end else begin
          $display("ok   wb_write: rd=%0d data=0x%08h", wb_addr, wb_data);
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_q_busy", 32'(q_busy), 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_count", 32'(count), 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single load: written one cycle later, queue drains.
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h5;
    #1 chk("single_ld_ready", 32'(ld_ready), 1);
    expect_wb(5'd5, 32'h5);
    tick();
    ld_valid = 1'b0;
    #1 chk("single_count_1", 32'(count), 1);
    chk("single_wb_we", 32'(wb_we), 1);
    tick();
    chk("single_count_0", 32'(count), 0);

    // Load has priority over ALU.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h77;
    #1 chk("prio_alu_ready", 32'(alu_ready), 0);
    chk("prio_ld_ready", 32'(ld_ready), 1);
    expect_wb(5'd7, 32'h77);
    tick();
    ld_valid = 1'b0;
    #1 chk("prio_alu_ready2", 32'(alu_ready), 1);
    expect_wb(5'd6, 32'h66);
    tick();
    alu_valid = 1'b0;
    tick(); tick();
    chk("prio_count_0", 32'(count), 0);

    // Write to x0 is swallowed.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1 chk("x0_alu_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    chk("x0_count", 32'(count), 0);
    tick(); tick();

    // Fill under stall; fifth load refused.
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'h11 * (i + 1);
      #1 chk($sformatf("fill_ld_ready_%0d", i), 32'(ld_ready), (i < 4) ? 1 : 0);
      if (i < 4) expect_wb(5'(i + 1), 32'h11 * (i + 1));
      tick();
    end
    ld_valid = 1'b0;
    #1 chk("full_count", 32'(count), 4);
    chk("full_ld_ready", 32'(ld_ready), 0);
    chk("full_wb_we", 32'(wb_we), 0);
    chk("full_head_addr", 32'(wb_addr), 1);
    chk("full_head_data", wb_data, 32'h11);

    // Release stall with a load pending: refused while registered-full, then accepted.
    wb_stall = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hCC;
    #1 chk("deq_full_ld_ready", 32'(ld_ready), 0);
    chk("drain_we_0", 32'(wb_we), 1);
    tick();
    #1 chk("after_deq_ld_ready", 32'(ld_ready), 1);
    expect_wb(5'd12, 32'hCC);
    chk("drain_we_1", 32'(wb_we), 1);
    tick();
    ld_valid = 1'b0;
    #1 chk("drain_count_mid", 32'(count), 3);
    chk("drain_we_2", 32'(wb_we), 1);
    tick();
    chk("drain_we_3", 32'(wb_we), 1);
    tick(); tick(); tick();
    chk("drain_count_0", 32'(count), 0);

    // Two queued writes to the same rd: busy query and youngest forward.
    wb_stall = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h4;
    expect_wb(5'd6, 32'h4);
    tick();
    ld_data = 32'h9;
    expect_wb(5'd6, 32'h9);
    tick();
    ld_valid = 1'b0;
    q_addr = 5'd6;
    #1 chk("q6_busy", 32'(q_busy), 1);
`ifdef WB_FORWARD_EN
    chk("q6_fwd_valid", 32'(q_fwd_valid), 1);
    chk("q6_fwd_data", q_fwd_data, 32'h9);
`endif
    q_addr = 5'd7;
    #1 chk("q7_busy", 32'(q_busy), 0);
    q_addr = 5'd0;
    #1 chk("q0_busy", 32'(q_busy), 0);
`ifdef WB_FORWARD_EN
    chk("q0_fwd_data", q_fwd_data, 32'h0);
`endif
    q_addr = 5'd6;
    wb_stall = 1'b0;
    tick();
    chk("q6_busy_last", 32'(q_busy), 1);
`ifdef WB_FORWARD_EN
    chk("q6_fwd_last", q_fwd_data, 32'h9);
`endif
    tick();
    chk("q6_busy_clear", 32'(q_busy), 0);
    q_addr = 5'd0;
    tick();

    // Reset mid-operation discards queued writes.
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_data = 32'hA0 + i;
      tick();
    end
    ld_valid = 1'b0;
    #1 chk("pre_rst_count", 32'(count), 3);
    rst = 1'b0;
    #1 chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_wb_we", 32'(wb_we), 0);
    chk("mid_rst_wb_addr", 32'(wb_addr), 0);
    tick();
    rst = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_count", 32'(count), 0);

    chk("scoreboard_left", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
